// File: rtl/agc_pkg.sv
// agc_pkg: shared FSM state type and gain-word constants for the AGC gain controller.
package agc_pkg;
   typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} agc_state_t;
   localparam logic [3:0] SHIFT_NONE = 4'd8;
   localparam logic [3:0] MULT_MIN = 4'd0;
   localparam logic [3:0] MULT_MAX = 4'd15;
   localparam logic [7:0] GAIN_CTRL_RST = {MULT_MIN, SHIFT_NONE};
endpackage

// File: rtl/agc_gain_controller_if.sv
// agc_gain_controller_if: scaler monitor stream into the AGC and gain word back out to the scaler.
interface agc_gain_controller_if #(parameter int DATA_WIDTH = 32);
   logic [DATA_WIDTH-1:0] mon_sample;
   logic mon_valid;
   logic [7:0] gain_control;
   logic gain_update;
   modport master (output mon_sample, mon_valid, input gain_control, gain_update);
   modport slave (input mon_sample, mon_valid, output gain_control, gain_update);
endinterface

// File: rtl/abs_peak_detector.sv
// abs_peak_detector: saturating two's-complement magnitude and running max with clear priority.
// With AGC_FAST_ATTACK_EN a full-scale flag for the current sample is exported.
module abs_peak_detector #(
   parameter int DATA_WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic valid,
   input  logic [DATA_WIDTH-1:0] sample,
   output logic [DATA_WIDTH-2:0] peak
`ifdef AGC_FAST_ATTACK_EN
   , output logic sat
`endif
);
   logic [DATA_WIDTH-1:0] neg;
   logic [DATA_WIDTH-2:0] mag;
   assign neg = -sample;
   // only the most-negative input still has its sign bit set after negation
   assign mag = !sample[DATA_WIDTH-1] ? sample[DATA_WIDTH-2:0] : neg[DATA_WIDTH-1] ? '1 : neg[DATA_WIDTH-2:0];
`ifdef AGC_FAST_ATTACK_EN
   assign sat = &mag;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         peak <= '0;
      else if (clr)
         peak <= '0;
      else if (valid && mag > peak)
         peak <= mag;
   end
endmodule

// File: rtl/agc_gain_controller.sv
// agc_gain_controller: closed-loop AGC stepping the scaler mult code from the windowed peak |sample|.
// Optional AGC_FAST_ATTACK_EN: a full-scale sample halves the mult code at once and aborts the window.
module agc_gain_controller
   import agc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WIN_LOG2 = 10,
   parameter int SETTLE_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   agc_gain_controller_if.slave m,
   input  logic agc_enable,
   input  logic [7:0] manual_gain,
   input  logic [DATA_WIDTH-2:0] thr_hi,
   input  logic [DATA_WIDTH-2:0] thr_lo,
   output logic [DATA_WIDTH-2:0] peak_out,
   output logic [1:0] agc_state,
   output logic locked
);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   agc_state_t state;
   logic [3:0] mult_q, mult_d;
   logic [WIN_LOG2-1:0] cnt;
   logic [SW-1:0] scnt;
   logic [DATA_WIDTH-2:0] peak;
   logic [7:0] gc_q, gc_d;
   logic upd_q, cfg_ok, go_dn, go_up, shift_chg, fast, clr, meas;
`ifdef AGC_FAST_ATTACK_EN
   logic sat;
`endif
   assign agc_state = state;
   assign m.gain_control = gc_q;
   assign m.gain_update = upd_q;
   assign meas = agc_enable && state == MEASURE;
   abs_peak_detector #(.DATA_WIDTH(DATA_WIDTH)) u_peak (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .valid(meas && m.mon_valid),
      .sample(m.mon_sample),
      .peak(peak)
`ifdef AGC_FAST_ATTACK_EN
      , .sat(sat)
`endif
   );
   always_comb begin
      cfg_ok = thr_lo < thr_hi;
      go_dn = cfg_ok && peak > thr_hi && mult_q != MULT_MIN;
      go_up = cfg_ok && peak < thr_lo && mult_q != MULT_MAX;
      shift_chg = manual_gain[3:0] != gc_q[3:0];
`ifdef AGC_FAST_ATTACK_EN
      fast = meas && m.mon_valid && sat && mult_q != MULT_MIN;
`else
      fast = 1'b0;
`endif
      mult_d = fast ? mult_q >> 1 : state != DECIDE ? mult_q : go_dn ? mult_q - 4'd1 : go_up ? mult_q + 4'd1 : mult_q;
      gc_d = (!agc_enable || state == IDLE) ? manual_gain : {mult_d, manual_gain[3:0]};
      // a host shift change restarts the window since earlier samples saw the old scaling
      clr = !meas || shift_chg || fast;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         mult_q <= MULT_MIN;
         cnt <= '0;
         scnt <= '0;
         gc_q <= GAIN_CTRL_RST;
         upd_q <= 1'b0;
         peak_out <= '0;
         locked <= 1'b0;
      end else begin
         gc_q <= gc_d;
         upd_q <= gc_d != gc_q;
         cnt <= '0;
         scnt <= '0;
         if (!agc_enable) begin
            state <= IDLE;
            locked <= 1'b0;
         end else begin
            mult_q <= mult_d;
            case (state)
               IDLE: begin
                  mult_q <= manual_gain[7:4];
                  state <= MEASURE;
               end
               MEASURE: begin
                  cnt <= (fast || shift_chg) ? '0 : cnt + WIN_LOG2'(m.mon_valid);
                  state <= fast ? SETTLE : (!shift_chg && m.mon_valid && &cnt) ? DECIDE : MEASURE;
                  if (fast) begin
                     peak_out <= '1;
                     locked <= 1'b0;
                  end
               end
               DECIDE: begin
                  peak_out <= peak;
                  locked <= !(go_dn || go_up);
                  state <= (go_dn || go_up) ? SETTLE : MEASURE;
               end
               default: begin
                  scnt <= scnt + SW'(1);
                  state <= scnt == SW'(SETTLE_CYC - 1) ? MEASURE : SETTLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_agc_gain_controller.sv
// tb_agc_gain_controller: directed vector table plus hand sequences for the AGC gain controller.
module tb_agc_gain_controller;
   typedef struct {
      logic [7:0] mg;
      logic [30:0] lo;
      logic [30:0] hi;
      logic [31:0] x;
      logic [7:0] gc;
      logic upd;
      logic lk;
      logic [1:0] st;
      logic [30:0] pk;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic agc_enable = 1'b0;
   logic [7:0] manual_gain = 8'h00;
   logic [30:0] thr_hi = 31'd1000;
   logic [30:0] thr_lo = 31'd100;
   logic [30:0] peak_out;
   logic [1:0] agc_state;
   logic locked;
   int ntests = 0;
   int nfail = 0;
   vec_t vt[11];

   agc_gain_controller_if #(.DATA_WIDTH(32)) bus();

   agc_gain_controller #(.DATA_WIDTH(32), .WIN_LOG2(4), .SETTLE_CYC(16)) dut (
      .clk(clk),
      .rst(rst),
      .m(bus),
      .agc_enable(agc_enable),
      .manual_gain(manual_gain),
      .thr_hi(thr_hi),
      .thr_lo(thr_lo),
      .peak_out(peak_out),
      .agc_state(agc_state),
      .locked(locked)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_state(input logic [1:0] s, input string nm);
      int n = 0;
      while (agc_state != s && n < 200) begin
         tick();
         n++;
      end
      chk(nm, {30'd0, agc_state}, {30'd0, s});
   endtask

   task automatic go_idle();
      agc_enable = 1'b0;
      bus.mon_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic start(input logic [7:0] mg, input logic [30:0] lo, input logic [30:0] hi);
      manual_gain = mg;
      thr_lo = lo;
      thr_hi = hi;
      agc_enable = 1'b1;
      tick();
   endtask

   task automatic run_vec(input vec_t v, input int i);
      go_idle();
      start(v.mg, v.lo, v.hi);
      bus.mon_sample = v.x;
      bus.mon_valid = 1'b1;
      repeat (16) tick();
      bus.mon_valid = 1'b0;
      chk($sformatf("v%0d_decide", i), {30'd0, agc_state}, 32'd2);
      tick();
      chk($sformatf("v%0d_gc", i), {24'd0, bus.gain_control}, {24'd0, v.gc});
      chk($sformatf("v%0d_upd", i), {31'd0, bus.gain_update}, {31'd0, v.upd});
      chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, v.lk});
      chk($sformatf("v%0d_state", i), {30'd0, agc_state}, {30'd0, v.st});
      chk($sformatf("v%0d_peak", i), {1'b0, peak_out}, {1'b0, v.pk});
   endtask

   initial begin
      int n;
      bus.mon_sample = '0;
      bus.mon_valid = 1'b0;
      vt[0]  = '{8'h38, 31'd100,  31'd1000, 32'd50,        8'h48, 1'b1, 1'b0, 2'd3, 31'd50};
      vt[1]  = '{8'h38, 31'd100,  31'd1000, 32'hFFFFF830,  8'h28, 1'b1, 1'b0, 2'd3, 31'd2000};
      vt[2]  = '{8'h38, 31'd100,  31'd1000, 32'd1000,      8'h38, 1'b0, 1'b1, 2'd1, 31'd1000};
      vt[3]  = '{8'h38, 31'd100,  31'd1000, 32'hFFFFFF9C,  8'h38, 1'b0, 1'b1, 2'd1, 31'd100};
      vt[4]  = '{8'hF5, 31'd100,  31'd1000, 32'd50,        8'hF5, 1'b0, 1'b1, 2'd1, 31'd50};
      vt[5]  = '{8'h03, 31'd100,  31'd1000, 32'd5000,      8'h03, 1'b0, 1'b1, 2'd1, 31'd5000};
      vt[6]  = '{8'h5A, 31'd2000, 31'd1000, 32'd1500,      8'h5A, 1'b0, 1'b1, 2'd1, 31'd1500};
      vt[7]  = '{8'h7C, 31'd100,  31'd1000, 32'hFFFFFC19,  8'h7C, 1'b0, 1'b1, 2'd1, 31'd999};
      vt[8]  = '{8'h7C, 31'd100,  31'd1000, 32'hFFFFFC17,  8'h6C, 1'b1, 1'b0, 2'd3, 31'd1001};
      vt[9]  = '{8'h7C, 31'd100,  31'd1000, 32'd99,        8'h8C, 1'b1, 1'b0, 2'd3, 31'd99};
      vt[10] = '{8'h1E, 31'd100,  31'd1000, 32'h7FFFFFFE,  8'h0E, 1'b1, 1'b0, 2'd3, 31'h7FFFFFFE};

      tick();
      tick();
      chk("rst_gc", {24'd0, bus.gain_control}, 32'h08);
      chk("rst_upd", {31'd0, bus.gain_update}, 32'd0);
      chk("rst_peak", {1'b0, peak_out}, 32'd0);
      chk("rst_state", {30'd0, agc_state}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      rst = 1'b0;

      manual_gain = 8'h38;
      tick();
      tick();
      chk("pt_38", {24'd0, bus.gain_control}, 32'h38);
      manual_gain = 8'h5A;
      chk("pt_latency", {24'd0, bus.gain_control}, 32'h38);
      tick();
      chk("pt_5a", {24'd0, bus.gain_control}, 32'h5A);
      chk("pt_upd", {31'd0, bus.gain_update}, 32'd1);
      tick();
      chk("pt_upd_end", {31'd0, bus.gain_update}, 32'd0);

      for (int i = 0; i < 11; i++) run_vec(vt[i], i);

      go_idle();
      start(8'h38, 31'd100, 31'd1000);
      bus.mon_sample = 32'd2000;
      bus.mon_valid = 1'b1;
      for (int w = 0; w < 5; w++) begin
         wait_state(2'd2, $sformatf("step%0d_decide", w));
         tick();
         chk($sformatf("step%0d_gc", w), {24'd0, bus.gain_control}, {24'd0, (w < 3 ? 4'(2 - w) : 4'd0), 4'h8});
         chk($sformatf("step%0d_locked", w), {31'd0, locked}, {31'd0, w >= 3});
         if (w == 0) begin
            n = 0;
            while (agc_state == 2'd3 && n < 50) begin
               tick();
               n++;
            end
            chk("settle_len", n, 32'd16);
            n = 0;
            while (agc_state == 2'd1 && n < 50) begin
               tick();
               n++;
            end
            chk("window_len", n, 32'd16);
         end
      end

      go_idle();
      start(8'h38, 31'd100, 31'd1000);
      n = 0;
      while (agc_state != 2'd2 && n < 40) begin
         bus.mon_valid = (n % 4) != 3;
         bus.mon_sample = n == 5 ? 32'hFFFFFDA8 : n == 7 ? 32'd5000 : 32'd10;
         tick();
         n++;
      end
      chk("gap_decide", {30'd0, agc_state}, 32'd2);
      bus.mon_valid = 1'b0;
      tick();
      chk("gap_peak", {1'b0, peak_out}, 32'd600);
      chk("gap_locked", {31'd0, locked}, 32'd1);
      chk("gap_gc", {24'd0, bus.gain_control}, 32'h38);

      go_idle();
      start(8'h88, 31'd100, 31'd1000);
      bus.mon_sample = 32'h80000000;
      bus.mon_valid = 1'b1;
`ifdef AGC_FAST_ATTACK_EN
      tick();
      bus.mon_valid = 1'b0;
      chk("neg_fast_gc", {24'd0, bus.gain_control}, 32'h48);
      chk("neg_fast_upd", {31'd0, bus.gain_update}, 32'd1);
      chk("neg_fast_state", {30'd0, agc_state}, 32'd3);
`else
      wait_state(2'd2, "neg_decide");
      bus.mon_valid = 1'b0;
      tick();
      chk("neg_gc", {24'd0, bus.gain_control}, 32'h78);
`endif
      chk("neg_peak", {1'b0, peak_out}, 32'h7FFFFFFF);

      go_idle();
      start(8'h38, 31'd100, 31'd1000);
      bus.mon_sample = 32'd50;
      bus.mon_valid = 1'b1;
      wait_state(2'd2, "drop_decide");
      bus.mon_valid = 1'b0;
      tick();
      chk("drop_settle", {30'd0, agc_state}, 32'd3);
      chk("drop_gc_up", {24'd0, bus.gain_control}, 32'h48);
      repeat (3) tick();
      agc_enable = 1'b0;
      tick();
      chk("drop_idle", {30'd0, agc_state}, 32'd0);
      chk("drop_gc", {24'd0, bus.gain_control}, 32'h38);
      chk("drop_upd", {31'd0, bus.gain_update}, 32'd1);

      start(8'h38, 31'd100, 31'd1000);
      bus.mon_valid = 1'b1;
      repeat (10) tick();
      manual_gain = 8'h36;
      bus.mon_valid = 1'b0;
      tick();
      chk("shift_gc", {24'd0, bus.gain_control}, 32'h36);
      chk("shift_upd", {31'd0, bus.gain_update}, 32'd1);
      bus.mon_valid = 1'b1;
      repeat (15) tick();
      chk("shift_restart", {30'd0, agc_state}, 32'd1);
      tick();
      chk("shift_decide", {30'd0, agc_state}, 32'd2);
      bus.mon_valid = 1'b0;
      tick();
      chk("shift_up_gc", {24'd0, bus.gain_control}, 32'h46);

      wait_state(2'd1, "mid_measure");
      bus.mon_valid = 1'b1;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_gc", {24'd0, bus.gain_control}, 32'h08);
      chk("arst_state", {30'd0, agc_state}, 32'd0);
      chk("arst_peak", {1'b0, peak_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.mon_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
